// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU function codes, FSM states and strobe bundle for the control unit
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDY  = 4'h1;
    localparam logic [3:0] OP_ALU  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JC   = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        FN_PASS = 3'b000,
        FN_INC  = 3'b001,
        FN_DEC  = 3'b010
    } ctl_fn_e;

    // ALU operations selected from IR[9:8] when selector=1
    typedef enum logic [1:0] {
        IR_ADD = 2'b00,
        IR_SUB = 2'b01,
        IR_AND = 2'b10,
        IR_OR  = 2'b11
    } ir_alu_e;

    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_F3, S_DEC, S_E0, S_E1, S_E2, S_E3, S_HALT
    } state_e;

    typedef struct packed {
        logic    ld_ir, ld_mar, ld_mdr, ld_sp, ld_pc, ld_y, ld_reg;
        logic    t_ir, t_mdr, t_sp, t_pc, t_y, t_reg;
        logic    selector;
        ctl_fn_e fn;
        logic    mem_rd, halted, illegal;
    } ctl_out_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h8) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts not-ready cycles of a memory read and flags the timeout cycle
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Held at zero outside a wait state, so every read starts from a clean count
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_cnt <= '0;
        end else if (!i_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            assign o_expired = i_active && !i_ready && (r_cnt == CW'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute control FSM for the single-bus datapath
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int FN_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      opcode,
    input  logic            status,
    input  logic            mem_ready,
    output logic            ld_ir,
    output logic            ld_mar,
    output logic            ld_mdr,
    output logic            ld_sp,
    output logic            ld_pc,
    output logic            ld_y,
    output logic            ld_reg,
    output logic            t_ir,
    output logic            t_mdr,
    output logic            t_sp,
    output logic            t_pc,
    output logic            t_y,
    output logic            t_reg,
    output logic            selector,
    output logic [FN_W-1:0] controller_fn,
    output logic            mem_rd,
    output logic            halted,
    output logic            mem_err,
    output logic            illegal
);

    state_e     r_state;
    state_e     w_next;
    logic [3:0] r_op;
    logic       r_mem_err;
    logic       w_expired;
    ctl_out_t   w_out;
    ctl_out_t   w_g;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_active  ((r_state == S_F1) || (r_state == S_E1)),
        .i_ready   (mem_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_F0;
            r_op      <= OP_NOP;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DEC) r_op <= opcode;
            if (w_expired) r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_out    = '0;
        w_out.fn = FN_PASS;
        case (r_state)
            S_F0: begin
                w_out.t_pc = 1'b1; w_out.ld_mar = 1'b1; w_next = S_F1;
            end
            S_F1, S_E1: begin
                w_out.mem_rd = 1'b1;
                if (mem_ready) begin
                    w_out.ld_mdr = 1'b1;
                    w_next = (r_state == S_F1) ? S_F2 : S_E2;
                end else if (w_expired) begin
                    w_next = S_HALT;
                end
            end
            S_F2: begin
                w_out.t_mdr = 1'b1; w_out.ld_ir = 1'b1; w_next = S_F3;
            end
            S_F3: begin
                w_out.t_pc = 1'b1; w_out.fn = FN_INC; w_out.ld_pc = 1'b1; w_next = S_DEC;
            end
            S_DEC: begin
                w_out.illegal = is_illegal(opcode);
                case (opcode)
                    OP_LDY, OP_ALU, OP_LDI, OP_JMP, OP_INC, OP_DEC: w_next = S_E0;
                    OP_JC:   w_next = status ? S_E0 : S_E3;
                    OP_HALT: w_next = S_HALT;
                    default: w_next = S_F0;
                endcase
            end
            S_E0: begin
                w_next = S_F0;
                case (r_op)
                    OP_LDY: begin w_out.t_reg = 1'b1; w_out.ld_y = 1'b1; end
                    OP_ALU: begin w_out.t_reg = 1'b1; w_out.selector = 1'b1; w_out.ld_reg = 1'b1; end
                    OP_INC: begin w_out.t_reg = 1'b1; w_out.fn = FN_INC; w_out.ld_reg = 1'b1; end
                    OP_DEC: begin w_out.t_reg = 1'b1; w_out.fn = FN_DEC; w_out.ld_reg = 1'b1; end
                    OP_LDI, OP_JMP, OP_JC: begin
                        w_out.t_pc = 1'b1; w_out.ld_mar = 1'b1; w_next = S_E1;
                    end
                    default: w_next = S_F0;
                endcase
            end
            S_E2: begin
                w_out.t_mdr = 1'b1;
                if (r_op == OP_LDI) begin
                    w_out.ld_reg = 1'b1; w_next = S_E3;
                end else begin
                    w_out.ld_pc = 1'b1; w_next = S_F0;
                end
            end
            S_E3: begin
                w_out.t_pc = 1'b1; w_out.fn = FN_INC; w_out.ld_pc = 1'b1; w_next = S_F0;
            end
            S_HALT:  w_out.halted = 1'b1;
            default: w_next = S_F0;
        endcase
    end

    // Everything is forced quiet while rst is asserted, whatever state was left behind
    assign w_g = rst ? '0 : w_out;

    assign ld_ir         = w_g.ld_ir;
    assign ld_mar        = w_g.ld_mar;
    assign ld_mdr        = w_g.ld_mdr;
    assign ld_sp         = w_g.ld_sp;
    assign ld_pc         = w_g.ld_pc;
    assign ld_y          = w_g.ld_y;
    assign ld_reg        = w_g.ld_reg;
    assign t_ir          = w_g.t_ir;
    assign t_mdr         = w_g.t_mdr;
    assign t_sp          = w_g.t_sp;
    assign t_pc          = w_g.t_pc;
    assign t_y           = w_g.t_y;
    assign t_reg         = w_g.t_reg;
    assign selector      = w_g.selector;
    assign controller_fn = FN_W'(w_g.fn);
    assign mem_rd        = w_g.mem_rd;
    assign halted        = w_g.halted;
    assign illegal       = w_g.illegal;
    assign mem_err       = r_mem_err && !rst;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a micro-step queue model
module tb_control_unit;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst, status, mem_ready;
    logic [3:0] opcode;
    logic       ld_ir, ld_mar, ld_mdr, ld_sp, ld_pc, ld_y, ld_reg;
    logic       t_ir, t_mdr, t_sp, t_pc, t_y, t_reg;
    logic       selector, mem_rd, halted, mem_err, illegal;
    logic [2:0] controller_fn;

    always #5 clk = ~clk;

    control_unit #(.MEM_TIMEOUT(TMO), .FN_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .status(status), .mem_ready(mem_ready),
        .ld_ir(ld_ir), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_sp(ld_sp), .ld_pc(ld_pc),
        .ld_y(ld_y), .ld_reg(ld_reg), .t_ir(t_ir), .t_mdr(t_mdr), .t_sp(t_sp), .t_pc(t_pc),
        .t_y(t_y), .t_reg(t_reg), .selector(selector), .controller_fn(controller_fn),
        .mem_rd(mem_rd), .halted(halted), .mem_err(mem_err), .illegal(illegal)
    );

    // Layout: ld_ir..ld_reg [18:12], t_ir..t_reg [11:6], selector [5], fn [4:2], mem_rd [1], illegal [0]
    typedef logic [18:0] vec_t;
    localparam vec_t M_LD_IR  = vec_t'(1) << 18;
    localparam vec_t M_LD_MAR = vec_t'(1) << 17;
    localparam vec_t M_LD_MDR = vec_t'(1) << 16;
    localparam vec_t M_LD_PC  = vec_t'(1) << 14;
    localparam vec_t M_LD_Y   = vec_t'(1) << 13;
    localparam vec_t M_LD_REG = vec_t'(1) << 12;
    localparam vec_t M_T_MDR  = vec_t'(1) << 10;
    localparam vec_t M_T_PC   = vec_t'(1) << 8;
    localparam vec_t M_T_REG  = vec_t'(1) << 6;
    localparam vec_t M_SEL    = vec_t'(1) << 5;
    localparam vec_t F_INC    = vec_t'(1) << 2;
    localparam vec_t F_DEC    = vec_t'(2) << 2;
    localparam vec_t M_RD     = vec_t'(1) << 1;
    localparam vec_t M_ILL    = vec_t'(1);

    localparam int K_FIX = 0, K_MEM = 1, K_DEC = 2, K_HALT = 3;
    typedef struct { int kind; vec_t v; } step_t;

    step_t q[$];
    int    wcnt = 0;
    logic  m_err = 1'b0;
    int    n_cmp = 0, n_bad = 0, cyc = 0;
    int    c_rd, c_mdr, c_reg, c_pc, c_mar, c_tmdr, c_ill, c_halt;

    int    rd_run = 0, rdy_delay = 0;
    bit    rdy_force = 1'b1, rnd = 1'b0, rst_v = 1'b1;

    task automatic push(input int k, input vec_t v);
        step_t s;
        s.kind = k; s.v = v;
        q.push_back(s);
    endtask

    task automatic push_exec(input logic [3:0] op, input logic st);
        case (op)
            4'h1: push(K_FIX, M_T_REG | M_LD_Y);
            4'h2: push(K_FIX, M_T_REG | M_SEL | M_LD_REG);
            4'h3: begin
                push(K_FIX, M_T_PC | M_LD_MAR); push(K_MEM, '0);
                push(K_FIX, M_T_MDR | M_LD_REG); push(K_FIX, M_T_PC | F_INC | M_LD_PC);
            end
            4'h4, 4'h5: begin
                if (op == 4'h4 || st) begin
                    push(K_FIX, M_T_PC | M_LD_MAR); push(K_MEM, '0);
                    push(K_FIX, M_T_MDR | M_LD_PC);
                end else begin
                    push(K_FIX, M_T_PC | F_INC | M_LD_PC);
                end
            end
            4'h6: push(K_FIX, M_T_REG | F_INC | M_LD_REG);
            4'h7: push(K_FIX, M_T_REG | F_DEC | M_LD_REG);
            4'hF: push(K_HALT, '0);
            default: ;
        endcase
    endtask

    task automatic check_cycle();
        vec_t  act_v, exp_v;
        logic  exp_h, exp_e, set_err;
        step_t s;
        act_v = {ld_ir, ld_mar, ld_mdr, ld_sp, ld_pc, ld_y, ld_reg, t_ir, t_mdr, t_sp, t_pc, t_y,
                 t_reg, selector, controller_fn, mem_rd, illegal};
        exp_v = '0; exp_h = 1'b0; exp_e = 1'b0; set_err = 1'b0;
        cyc++;
        if (rst) begin
            q.delete(); wcnt = 0; m_err = 1'b0;
        end else begin
            if (q.size() == 0) begin
                push(K_FIX, M_T_PC | M_LD_MAR); push(K_MEM, '0); push(K_FIX, M_T_MDR | M_LD_IR);
                push(K_FIX, M_T_PC | F_INC | M_LD_PC); push(K_DEC, '0);
            end
            s = q[0];
            exp_e = m_err;
            case (s.kind)
                K_FIX: begin exp_v = s.v; void'(q.pop_front()); end
                K_MEM: begin
                    exp_v = M_RD | (mem_ready ? M_LD_MDR : vec_t'(0));
                    if (mem_ready) begin
                        void'(q.pop_front()); wcnt = 0;
                    end else begin
                        wcnt++;
                        if (TMO != 0 && wcnt == TMO) begin
                            q.delete(); push(K_HALT, '0); wcnt = 0; set_err = 1'b1;
                        end
                    end
                end
                K_DEC: begin
                    exp_v = (opcode >= 4'h8 && opcode <= 4'hE) ? M_ILL : vec_t'(0);
                    void'(q.pop_front());
                    push_exec(opcode, status);
                end
                default: exp_h = 1'b1;
            endcase
        end
        n_cmp++;
        if (act_v !== exp_v || halted !== exp_h || mem_err !== exp_e) begin
            n_bad++;
            $display("FAIL outs cycle %0d: got %b h=%b e=%b, want %b h=%b e=%b",
                     cyc, act_v, halted, mem_err, exp_v, exp_h, exp_e);
        end
        n_cmp++;
        if ($countones(act_v[11:6]) > 1) begin
            n_bad++;
            $display("FAIL bus_onehot cycle %0d: t bits %b, want at most one high", cyc, act_v[11:6]);
        end
        if (set_err) m_err = 1'b1;
        c_rd += int'(mem_rd); c_mdr += int'(ld_mdr); c_reg += int'(ld_reg); c_pc += int'(ld_pc);
        c_mar += int'(ld_mar); c_tmdr += int'(t_mdr); c_ill += int'(illegal); c_halt += int'(halted);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd) begin
                rst       = ($urandom_range(0, 39) == 0);
                opcode    = 4'($urandom);
                status    = 1'($urandom);
                mem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rst_run_update();
                rst       = rst_v;
                mem_ready = rdy_force || (rd_run > rdy_delay);
            end
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic rst_run_update();
        rd_run = mem_rd ? rd_run + 1 : 0;
    endtask

    task automatic clr();
        c_rd = 0; c_mdr = 0; c_reg = 0; c_pc = 0; c_mar = 0; c_tmdr = 0; c_ill = 0; c_halt = 0;
    endtask

    task automatic do_reset();
        rst_v = 1'b1; run(2); rst_v = 1'b0; clr();
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; status = 1'b0; mem_ready = 1'b1;
        clr();
        run(3);
        rst_v = 1'b0;
        run(1);
        chk("first_f0", int'({t_pc, ld_mar, mem_rd}), 6);
        rdy_force = 1'b0;

        opcode = 4'h3; rdy_delay = 5;
        do_reset(); run(19);
        chk("ldi_mem_rd", c_rd, 12); chk("ldi_ld_mdr", c_mdr, 2);
        chk("ldi_ld_reg", c_reg, 1); chk("ldi_ld_pc", c_pc, 2);
        run(1);
        chk("ldi_back_f0", int'({t_pc, ld_mar}), 3);

        opcode = 4'h5; status = 1'b0; rdy_delay = 0;
        do_reset(); run(6);
        chk("jc0_ld_mar", c_mar, 1); chk("jc0_ld_pc", c_pc, 2); chk("jc0_mem_rd", c_rd, 1);
        run(1);
        chk("jc0_back_f0", int'({t_pc, ld_mar}), 3);
        status = 1'b1;
        do_reset(); run(8);
        chk("jc1_ld_mar", c_mar, 2); chk("jc1_ld_pc", c_pc, 2); chk("jc1_t_mdr", c_tmdr, 2);

        opcode = 4'h0; rdy_delay = 1000;
        do_reset(); run(20);
        chk("tmo_mem_rd", c_rd, TMO); chk("tmo_halted", int'(halted), 1); chk("tmo_err", int'(mem_err), 1);
        rdy_force = 1'b1; run(5); rdy_force = 1'b0;
        chk("tmo_ready_ignored", c_rd, TMO); chk("tmo_still_halted", int'(halted), 1);
        rdy_delay = 0;

        opcode = 4'h9;
        do_reset(); run(5);
        chk("ill_pulses", c_ill, 1);
        run(1);
        chk("ill_back_f0", int'({t_pc, ld_mar}), 3);
        opcode = 4'hF;
        do_reset(); run(15);
        chk("halt_cycles", c_halt, 10);
        rst_v = 1'b1; run(1); rst_v = 1'b0;
        chk("halt_cleared", int'(halted), 0);

        rnd = 1'b1; run(10000); rnd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
